block_max_exp_acc: RTL and testbench
====================================

Name: block_max_exp_acc

Overview:
- Streaming, pipelined maximum-exponent finder for block-floating-point FFT normalisation.
- Each beat carries LANES unsigned exponents. The block reduces each beat to its maximum, then accumulates across a block of up to BEATS beats.
- At block end it emits the block maximum exponent and the flat index of its first occurrence.
- Sits between butterfly output staging and the shift/normalise stage. Uses valid/ready handshakes on both sides.

Parameters:
- expWidth, 4, width of one unsigned exponent.
- LANES, 32, exponents per input beat (>=1, any value).
- BEATS, 4, maximum beats per block (>=1); a block also closes early on in_last.
- IDXW, derived = max(1, clog2(LANES*BEATS)), width of out_idx (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_exp  input  LANES*expWidth  packed exponents; lane k = bits [expWidth*(k+1)-1 : expWidth*k].
- in_last  input  1  final beat of the block (optional early close); sampled only with the handshake.
- out_valid  output  1  block result available.
- out_ready  input  1  consumer accepts the result.
- out_exp  output  expWidth  block maximum exponent.
- out_idx  output  IDXW  beat*LANES + lane of the first (lowest-index) maximum.
- out_beats  output  clog2(BEATS+1)  number of beats in the reported block (1..BEATS).

Behaviour:
- Reset (async assert, sync deassert by the clock edge):
  - out_valid=0, out_exp=0, out_idx=0, out_beats=0.
  - Stage-A valid=0; beat counter cnt=0; accumulator cleared.
  - in_ready follows its equation and is therefore 1 after reset.
- Advance rule: adv = !out_valid || out_ready. in_ready = adv. The whole pipe freezes when adv=0: stage A and the accumulator hold, and no beat is accepted.
- Stage A (registered), on each edge with adv=1:
  - a_valid <= in_valid.
  - When in_valid, also load:
    - a_max = max over lanes.
    - a_lane = lowest lane holding a_max.
    - a_last = in_last.
  - Lane reduction is combinational (tree of unsigned compares). Ties resolve to the lower lane.
- Stage B (accumulator, cnt in 0..BEATS-1), on each edge with adv=1 and a_valid=1:
  - Candidate value/index:
    - If cnt==0: candidate = (a_max, a_lane).
    - Otherwise: candidate = (a_max, cnt*LANES+a_lane) only if a_max > acc_max (strict), else (acc_max, acc_idx). The strict compare keeps the earliest occurrence.
  - End of block = a_last || cnt==BEATS-1. At end of block:
    - out_exp/out_idx <= candidate.
    - out_beats <= cnt+1.
    - out_valid <= 1.
    - cnt <= 0.
  - Otherwise: acc <= candidate, cnt <= cnt+1.
- out_valid clearing: with adv=1 and no end of block this cycle, out_valid <= 0 if out_ready. A new end-of-block result in the same cycle as out_ready=1 replaces the old result with no bubble.
- Latency: last beat accepted at edge t -> stage A at t -> out_valid=1 after edge t+1.
  - Throughput: one beat per cycle while out_ready=1.
  - For BEATS=1, one result per cycle.
- Output stability: out_exp, out_idx and out_beats stay stable while out_valid && !out_ready.
- in_last with cnt==BEATS-1 is a single close, not a double close. A block never exceeds BEATS beats.
- in_valid=0 bubbles mid-block leave cnt and acc untouched.
- Reset mid-block discards the partial block. The next accepted beat starts a fresh block with cnt=0, and no stale accumulator value contributes.
- Exponents are unsigned. All-zero input yields out_exp=0, out_idx=0.

Test Plan:
1. expWidth=4, LANES=32, BEATS=4. Four beats, all lanes 0x3 except beat2 lane5=0xC. Expect out_exp=0xC, out_idx=69, out_beats=4, out_valid high 2 edges after the 4th beat is accepted, for exactly one cycle with out_ready=1.
2. Tie: beat0 lane31=0xF and beat1 lane0=0xF, others 0x1. Expect out_exp=0xF, out_idx=31 (first occurrence wins).
3. in_last on beat1, max 0x9 at beat1 lane2. Expect out_exp=0x9, out_idx=34, out_beats=2. The following block of 4 beats (max 0x4 at beat3 lane0) gives out_idx=96 and is unaffected by the earlier 0x9.
4. Continuous in_valid, out_ready held low 5 cycles while out_valid=1. Expect in_ready=0 and outputs stable during the stall. After release, all beats appear in later results with none lost or duplicated; compare against a scoreboard.
5. Load 2 beats containing 0xE, then pulse rst_n low mid-block. Expect all outputs 0 immediately. A new 4-beat block with max 0x3 at beat0 lane0 gives out_exp=0x3, out_idx=0.
6. BEATS=1, LANES=8, back-to-back beats with out_ready=1 and in_valid gaps inserted. Expect one result per accepted beat, each with out_beats=1, and bubbles produce no spurious out_valid.

Source files
------------

// File: rtl/block_max_exp_acc.sv
// Streaming block-maximum exponent finder: per-beat lane reduction (stage A)
// followed by a cross-beat accumulator that reports max exponent, first index and beat count.
module block_max_exp_acc #(
    parameter  int expWidth = 4,
    parameter  int LANES    = 32,
    parameter  int BEATS    = 4,
    localparam int IDXW     = (LANES * BEATS > 1) ? $clog2(LANES * BEATS) : 1,
    localparam int BW       = $clog2(BEATS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*expWidth-1:0] in_exp,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [expWidth-1:0]       out_exp,
    output logic [IDXW-1:0]           out_idx,
    output logic [BW-1:0]             out_beats
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int P  = 1 << $clog2(LANES);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                  adv;
    logic [P*expWidth-1:0] exp_pad;
    logic [expWidth-1:0]   lane_max;
    logic [LW-1:0]         lane_idx;

    logic                  a_valid_q, a_valid_d;
    logic [expWidth-1:0]   a_max_q, a_max_d;
    logic [LW-1:0]         a_lane_q, a_lane_d;
    logic                  a_last_q, a_last_d;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [expWidth-1:0]   acc_max_q, acc_max_d;
    logic [IDXW-1:0]       acc_idx_q, acc_idx_d;

    logic                  out_valid_q, out_valid_d;
    logic [expWidth-1:0]   out_exp_q, out_exp_d;
    logic [IDXW-1:0]       out_idx_q, out_idx_d;
    logic [BW-1:0]         out_beats_q, out_beats_d;

    logic [expWidth-1:0]   cand_max;
    logic [IDXW-1:0]       cand_idx;
    logic                  eob;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign exp_pad  = (P * expWidth)'(in_exp);

    // Heap-ordered compare tree; padding lanes sit above LANES and hold 0, so they never
    // win against a real lane because ties always go to the left (lower-lane) child.
    always_comb begin : lane_tree
        logic [expWidth-1:0] tv [2*P-1];
        logic [LW-1:0]       ti [2*P-1];
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        for (int k = 0; k < P; k++) begin
            tv[P-1+k] = exp_pad[k*expWidth +: expWidth];
            ti[P-1+k] = LW'(k);
        end
        for (int i = P - 2; i >= 0; i--) begin
            if (tv[2*i+2] > tv[2*i+1]) begin
                tv[i] = tv[2*i+2];
                ti[i] = ti[2*i+2];
            end else begin
                tv[i] = tv[2*i+1];
                ti[i] = ti[2*i+1];
            end
        end
        lane_max = tv[0];
        lane_idx = ti[0];
    end

    always_comb begin
        a_valid_d = a_valid_q;
        a_max_d   = a_max_q;
        a_lane_d  = a_lane_q;
        a_last_d  = a_last_q;
        if (adv) begin
            a_valid_d = in_valid;
            if (in_valid) begin
                a_max_d  = lane_max;
                a_lane_d = lane_idx;
                a_last_d = in_last;
            end
        end
    end

    // Strict compare on later beats keeps the earliest occurrence of the maximum.
    always_comb begin
        cand_max = acc_max_q;
        cand_idx = acc_idx_q;
        if (cnt_q == '0) begin
            cand_max = a_max_q;
            cand_idx = IDXW'(a_lane_q);
        end else if (a_max_q > acc_max_q) begin
            cand_max = a_max_q;
            cand_idx = IDXW'(cnt_q) * IDXW'(LANES) + IDXW'(a_lane_q);
        end
        eob = a_last_q || (cnt_q == CW'(BEATS - 1));
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_max_d   = acc_max_q;
        acc_idx_d   = acc_idx_q;
        out_valid_d = out_valid_q;
        out_exp_d   = out_exp_q;
        out_idx_d   = out_idx_q;
        out_beats_d = out_beats_q;
        if (adv) begin
            // adv implies the current result is either absent or being taken this cycle.
            out_valid_d = 1'b0;
            if (a_valid_q) begin
                if (eob) begin
                    out_valid_d = 1'b1;
                    out_exp_d   = cand_max;
                    out_idx_d   = cand_idx;
                    out_beats_d = BW'(cnt_q) + BW'(1);
                    cnt_d       = '0;
                end else begin
                    acc_max_d = cand_max;
                    acc_idx_d = cand_idx;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q   <= 1'b0;
            a_max_q     <= '0;
            a_lane_q    <= '0;
            a_last_q    <= 1'b0;
            cnt_q       <= '0;
            acc_max_q   <= '0;
            acc_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_exp_q   <= '0;
            out_idx_q   <= '0;
            out_beats_q <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_max_q     <= a_max_d;
            a_lane_q    <= a_lane_d;
            a_last_q    <= a_last_d;
            cnt_q       <= cnt_d;
            acc_max_q   <= acc_max_d;
            acc_idx_q   <= acc_idx_d;
            out_valid_q <= out_valid_d;
            out_exp_q   <= out_exp_d;
            out_idx_q   <= out_idx_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_exp   = out_exp_q;
    assign out_idx   = out_idx_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_block_max_exp_acc.sv
// Scoreboard bench for block_max_exp_acc: a 32-lane/4-beat instance and an 8-lane/1-beat instance.
module tb_block_max_exp_acc;

    typedef struct packed {
        logic [3:0] e;
        logic [6:0] i;
        logic [2:0] b;
    } exp_t;

    logic         clk;
    logic         rst_n;

    logic         in_valid, in_ready, in_last, out_valid, out_ready;
    logic [127:0] in_exp;
    logic [3:0]   out_exp;
    logic [6:0]   out_idx;
    logic [2:0]   out_beats;

    logic         in_valid2, in_ready2, in_last2, out_valid2, out_ready2;
    logic [31:0]  in_exp2;
    logic [3:0]   out_exp2;
    logic [2:0]   out_idx2;
    logic [0:0]   out_beats2;

    exp_t sb1[$];
    exp_t sb2[$];
    exp_t m1_e, m2_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_res2 = 0;

    block_max_exp_acc #(.expWidth(4), .LANES(32), .BEATS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_exp(in_exp), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exp(out_exp), .out_idx(out_idx), .out_beats(out_beats)
    );

    block_max_exp_acc #(.expWidth(4), .LANES(8), .BEATS(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_exp(in_exp2), .in_last(in_last2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_exp(out_exp2), .out_idx(out_idx2), .out_beats(out_beats2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop and compare whenever a result is handed over.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb1.size() == 0) check("dut1 unexpected result", 32'd1, 32'd0);
            else begin
                m1_e = sb1.pop_front();
                check("dut1 out_exp", 32'(out_exp), 32'(m1_e.e));
                check("dut1 out_idx", 32'(out_idx), 32'(m1_e.i));
                check("dut1 out_beats", 32'(out_beats), 32'(m1_e.b));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid2 && out_ready2) begin
            n_res2++;
            if (sb2.size() == 0) check("dut2 unexpected result", 32'd1, 32'd0);
            else begin
                m2_e = sb2.pop_front();
                check("dut2 out_exp", 32'(out_exp2), 32'(m2_e.e));
                check("dut2 out_idx", 32'(out_idx2), 32'(m2_e.i));
                check("dut2 out_beats", 32'(out_beats2), 32'(m2_e.b));
            end
        end
    end

    function automatic logic [127:0] fill(input logic [3:0] v);
        logic [127:0] r;
        for (int k = 0; k < 32; k++) r[k*4 +: 4] = v;
        return r;
    endfunction

    function automatic exp_t mk(input logic [3:0] e, input logic [6:0] i, input logic [2:0] b);
        exp_t r;
        r.e = e; r.i = i; r.b = b;
        return r;
    endfunction

    // Called just after a posedge; returns just after the edge that accepted the beat.
    task automatic send1(input logic [127:0] v, input logic last);
        bit done = 0;
        int n = 0;
        in_valid = 1'b1; in_exp = v; in_last = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk); #1;
            n++;
            if (!done && n > 200) begin
                check("send1 timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
    endtask

    task automatic send2(input logic [31:0] v, input logic last);
        bit done = 0;
        int n = 0;
        in_valid2 = 1'b1; in_exp2 = v; in_last2 = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready2) done = 1;
            @(posedge clk); #1;
            n++;
            if (!done && n > 200) begin
                check("send2 timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0; in_last = 1'b0;
        in_valid2 = 1'b0; in_last2 = 1'b0;
        repeat (cycles) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb1.size() != 0 || sb2.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain queues empty", 32'(sb1.size() + sb2.size()), 32'd0);
    endtask

    logic [127:0] v;

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_last = 0; in_exp = '0; out_ready = 1'b1;
        in_valid2 = 0; in_last2 = 0; in_exp2 = '0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_exp", 32'(out_exp), 32'd0);
        check("reset out_idx", 32'(out_idx), 32'd0);
        check("reset out_beats", 32'(out_beats), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset dut2 out_valid", 32'(out_valid2), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: single peak in beat 2 lane 5, then latency and one-cycle pulse.
        sb1.push_back(mk(4'hC, 7'd69, 3'd4));
        send1(fill(4'h3), 1'b0);
        send1(fill(4'h3), 1'b0);
        v = fill(4'h3); v[5*4 +: 4] = 4'hC;
        send1(v, 1'b0);
        send1(fill(4'h3), 1'b0);
        idle(0);
        check("t1 out_valid one edge after last beat", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("t1 out_valid two edges after last beat", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        check("t1 out_valid single cycle", 32'(out_valid), 32'd0);
        drain();

        // Test 2: tie across beats; in_last together with the final beat is a single close.
        sb1.push_back(mk(4'hF, 7'd31, 3'd4));
        v = fill(4'h1); v[31*4 +: 4] = 4'hF;
        send1(v, 1'b0);
        v = fill(4'h1); v[0 +: 4] = 4'hF;
        send1(v, 1'b0);
        send1(fill(4'h1), 1'b0);
        send1(fill(4'h1), 1'b1);
        idle(1);
        drain();

        // Test 3: early close, then a fresh block with mid-block bubbles.
        sb1.push_back(mk(4'h9, 7'd34, 3'd2));
        sb1.push_back(mk(4'h4, 7'd96, 3'd4));
        send1(fill(4'h1), 1'b0);
        v = fill(4'h1); v[2*4 +: 4] = 4'h9;
        send1(v, 1'b1);
        send1(fill(4'h2), 1'b0);
        idle(2);
        send1(fill(4'h2), 1'b0);
        send1(fill(4'h2), 1'b0);
        idle(1);
        v = fill(4'h2); v[0 +: 4] = 4'h4;
        send1(v, 1'b0);
        idle(1);
        drain();

        // Test 4: continuous input with the consumer stalled for five cycles.
        sb1.push_back(mk(4'hA, 7'd39, 3'd4));
        sb1.push_back(mk(4'h8, 7'd127, 3'd4));
        out_ready = 1'b0;
        fork
            begin
                for (int b = 0; b < 8; b++) begin
                    v = (b < 4) ? fill(4'h5) : fill(4'h2);
                    if (b == 1) v[7*4 +: 4] = 4'hA;
                    if (b == 7) v[31*4 +: 4] = 4'h8;
                    send1(v, 1'b0);
                end
                idle(0);
            end
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 100);
                check("t4 result before stall timeout", 32'(out_valid), 32'd1);
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    check("t4 stall in_ready", 32'(in_ready), 32'd0);
                    check("t4 stall out_valid", 32'(out_valid), 32'd1);
                    check("t4 stall out_exp", 32'(out_exp), 32'hA);
                    check("t4 stall out_idx", 32'(out_idx), 32'd39);
                    check("t4 stall out_beats", 32'(out_beats), 32'd4);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(1);
        drain();

        // Test 5: reset in the middle of a block discards it.
        send1(fill(4'hE), 1'b0);
        send1(fill(4'hE), 1'b0);
        idle(0);
        #2 rst_n = 1'b0;
        #1;
        check("t5 reset out_valid", 32'(out_valid), 32'd0);
        check("t5 reset out_exp", 32'(out_exp), 32'd0);
        check("t5 reset out_idx", 32'(out_idx), 32'd0);
        check("t5 reset out_beats", 32'(out_beats), 32'd0);
        check("t5 reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        sb1.push_back(mk(4'h3, 7'd0, 3'd4));
        v = fill(4'h0); v[0 +: 4] = 4'h3;
        send1(v, 1'b0);
        send1(fill(4'h1), 1'b0);
        v = fill(4'h0); v[4*4 +: 4] = 4'h3;
        send1(v, 1'b0);
        send1(fill(4'h2), 1'b0);
        idle(1);
        drain();

        // Test 6: single-beat blocks with bubbles in between.
        n_res2 = 0;
        sb2.push_back(mk(4'h7, 7'd3, 3'd1));
        sb2.push_back(mk(4'h0, 7'd0, 3'd1));
        sb2.push_back(mk(4'hF, 7'd7, 3'd1));
        sb2.push_back(mk(4'h9, 7'd0, 3'd1));
        sb2.push_back(mk(4'h5, 7'd2, 3'd1));
        send2(32'h0007_7321, 1'b0);
        send2(32'h0000_0000, 1'b0);
        idle(1);
        send2(32'hF444_4444, 1'b1);
        idle(2);
        send2(32'h2922_2229, 1'b0);
        send2(32'h0000_0500, 1'b0);
        idle(4);
        drain();
        check("t6 result count", 32'(n_res2), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
